ctrl_seq: RTL and testbench

//  Multi-cycle control sequencer for the 16-bit RISC core. Steps each instruction through

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/ctrl_wait_timer.sv | 29 ++
 rtl/ctrl_seq.sv | 117 +++++++++++
 tb/tb_ctrl_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the RISC control sequencer: state encoding, opcode classes
// and opcode classification helpers.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_REGRD  = 3'd3,
      S_EXEC   = 3'd4,
      S_MEM    = 3'd5,
      S_WB     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   // Classes are matched on opcode[4:1]; HALT is the one full 5-bit code.
   localparam logic [3:0] OPC_STORE  = 4'b0111;
   localparam logic [3:0] OPC_LOAD   = 4'b1000;
   localparam logic [3:0] OPC_BRANCH = 4'b1100;
   localparam logic [3:0] OPC_JUMP   = 4'b1101;
   localparam logic [4:0] OPC_HALT   = 5'b11111;

   function automatic logic is_store(input logic [4:0] opcode);
      return opcode[4:1] == OPC_STORE;
   endfunction

   function automatic logic is_load(input logic [4:0] opcode);
      return opcode[4:1] == OPC_LOAD;
   endfunction

   function automatic logic is_branch(input logic [4:0] opcode);
      return opcode[4:1] == OPC_BRANCH;
   endfunction

   function automatic logic is_jump(input logic [4:0] opcode);
      return opcode[4:1] == OPC_JUMP;
   endfunction

   function automatic logic is_halt(input logic [4:0] opcode);
      return opcode == OPC_HALT;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state timer: counts cycles without ready while a request is open
// and flags expiry on the last allowed cycle unless ready arrives in it.
module ctrl_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   input  logic ready,
   output logic expired
);

   localparam int W = $clog2(MEM_TIMEOUT);
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (count && !ready && cnt != LAST) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = count && !ready && (cnt == LAST);

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 16-bit RISC core: FSM, strobe decode
// and retired-instruction counter.
//
// state    | meaning
// S_RST    | in reset / first cycle after reset
// S_FETCH  | instruction fetch, waiting for i_mem_ready
// S_DECODE | decoder captures instruction
// S_REGRD  | register-file read
// S_EXEC   | ALU operation, class dispatch
// S_MEM    | data-memory access (load/store), waiting for i_mem_ready
// S_WB     | write-back and PC update, retires instruction
// S_HALT   | stopped (HALT opcode or memory timeout); only reset exits
module ctrl_seq
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_opcode,
   input  logic             i_mem_ready,
   input  logic             i_branch_taken,
   output logic             o_fetch_req,
   output logic             o_dec_en,
   output logic             o_rf_rd_en,
   output logic             o_alu_en,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_rf_we_en,
   output logic             o_pc_inc,
   output logic             o_pc_load,
   output logic [2:0]       o_state,
   output logic             o_halted,
   output logic             o_err_timeout,
   output logic [CNT_W-1:0] o_retired
);

   state_t state;
   logic   waiting;
   logic   expired;
   logic   take_pc;

   assign waiting = (state == S_FETCH) || (state == S_MEM);

   ctrl_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk    (i_clk),
      .rst    (i_rst),
      .clear  (!waiting),
      .count  (waiting),
      .ready  (i_mem_ready),
      .expired(expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_RST;
         o_err_timeout <= 1'b0;
         o_retired     <= '0;
      end else begin
         case (state)
            S_RST:    state <= S_FETCH;
            S_FETCH: begin
               if (i_mem_ready) begin
                  state <= S_DECODE;
               end else if (expired) begin
                  state         <= S_HALT;
                  o_err_timeout <= 1'b1;
               end
            end
            S_DECODE: state <= S_REGRD;
            S_REGRD:  state <= S_EXEC;
            S_EXEC: begin
               if (is_halt(i_opcode)) begin
                  state <= S_HALT;
               end else if (is_load(i_opcode) || is_store(i_opcode)) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (i_mem_ready) begin
                  state <= S_WB;
               end else if (expired) begin
                  state         <= S_HALT;
                  o_err_timeout <= 1'b1;
               end
            end
            S_WB: begin
               state     <= S_FETCH;
               o_retired <= o_retired + CNT_W'(1);
            end
            default:  state <= S_HALT;
         endcase
      end
   end

   // WB decode relies on the decoder holding the opcode stable through the instruction.
   assign take_pc = is_jump(i_opcode) || (is_branch(i_opcode) && i_branch_taken);

   assign o_state     = state;
   assign o_fetch_req = (state == S_FETCH);
   assign o_dec_en    = (state == S_DECODE);
   assign o_rf_rd_en  = (state == S_REGRD);
   assign o_alu_en    = (state == S_EXEC);
   assign o_mem_req   = (state == S_MEM);
   assign o_mem_we    = (state == S_MEM) && is_store(i_opcode);
   assign o_rf_we_en  = (state == S_WB) && !is_store(i_opcode) && !is_branch(i_opcode)
                        && !is_jump(i_opcode);
   assign o_pc_load   = (state == S_WB) && take_pc;
   assign o_pc_inc    = (state == S_WB) && !take_pc;
   assign o_halted    = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-cycle state/strobe vectors against hand-built
// expectations for each instruction class, wait states, timeout, HALT and reset.
module tb_ctrl_seq;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [4:0]  i_opcode = 5'b00000;
   logic        i_mem_ready = 1'b0;
   logic        i_branch_taken = 1'b0;
   logic        o_fetch_req, o_dec_en, o_rf_rd_en, o_alu_en, o_mem_req, o_mem_we;
   logic        o_rf_we_en, o_pc_inc, o_pc_load, o_halted, o_err_timeout;
   logic [2:0]  o_state;
   logic [15:0] o_retired;

   int n_pass  = 0;
   int n_total = 0;

   always #5 i_clk = ~i_clk;

   ctrl_seq #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_opcode      (i_opcode),
      .i_mem_ready   (i_mem_ready),
      .i_branch_taken(i_branch_taken),
      .o_fetch_req   (o_fetch_req),
      .o_dec_en      (o_dec_en),
      .o_rf_rd_en    (o_rf_rd_en),
      .o_alu_en      (o_alu_en),
      .o_mem_req     (o_mem_req),
      .o_mem_we      (o_mem_we),
      .o_rf_we_en    (o_rf_we_en),
      .o_pc_inc      (o_pc_inc),
      .o_pc_load     (o_pc_load),
      .o_state       (o_state),
      .o_halted      (o_halted),
      .o_err_timeout (o_err_timeout),
      .o_retired     (o_retired)
   );

   // {state, fetch, dec, rd, alu, mem_req, mem_we, rf_we, pc_inc, pc_load, halted, err}
   logic [13:0] obs;
   assign obs = {o_state, o_fetch_req, o_dec_en, o_rf_rd_en, o_alu_en, o_mem_req, o_mem_we,
                 o_rf_we_en, o_pc_inc, o_pc_load, o_halted, o_err_timeout};

   localparam logic [13:0] E_RST = {3'd0, 11'h000};
   localparam logic [13:0] E_F   = {3'd1, 11'h400};
   localparam logic [13:0] E_D   = {3'd2, 11'h200};
   localparam logic [13:0] E_R   = {3'd3, 11'h100};
   localparam logic [13:0] E_E   = {3'd4, 11'h080};
   localparam logic [13:0] E_ML  = {3'd5, 11'h040};
   localparam logic [13:0] E_MS  = {3'd5, 11'h060};
   localparam logic [13:0] E_WA  = {3'd6, 11'h018};
   localparam logic [13:0] E_WI  = {3'd6, 11'h008};
   localparam logic [13:0] E_WL  = {3'd6, 11'h004};
   localparam logic [13:0] E_H   = {3'd7, 11'h002};
   localparam logic [13:0] E_HE  = {3'd7, 11'h003};

   localparam logic [4:0] OP_ALU    = 5'b00010;
   localparam logic [4:0] OP_STORE  = 5'b01110;
   localparam logic [4:0] OP_LOAD   = 5'b10000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JUMP   = 5'b11010;
   localparam logic [4:0] OP_HALT   = 5'b11111;

   // Leaves the DUT one posedge away from entering FETCH.
   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      i_mem_ready = 1'b0;
      i_branch_taken = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      n_total++;
      if (obs !== E_RST) $display("FAIL reset_outputs: got %h want %h", obs, E_RST);
      else n_pass++;
      n_total++;
      if (o_retired !== 16'd0) $display("FAIL reset_retired: got %0d want 0", o_retired);
      else n_pass++;
      i_rst = 1'b0;
      i_mem_ready = 1'b1;
      @(negedge i_clk);
      n_total++;
      if (obs !== E_F) $display("FAIL reset_to_fetch: got %h want %h", obs, E_F);
      else n_pass++;
      @(negedge i_clk);
      n_total++;
      if (obs !== E_D) $display("FAIL reset_fetch_to_decode: got %h want %h", obs, E_D);
      else n_pass++;
   endtask

   task automatic test_alu();
      logic [13:0] exp_s [6] = '{E_F, E_D, E_R, E_E, E_WA, E_F};
      do_reset();
      i_opcode = OP_ALU;
      i_mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_s[i]) $display("FAIL alu_cyc%0d: got %h want %h", i, obs, exp_s[i]);
         else n_pass++;
      end
      n_total++;
      if (o_retired !== 16'd1) $display("FAIL alu_retired: got %0d want 1", o_retired);
      else n_pass++;
   endtask

   task automatic test_store_wait();
      logic [13:0] exp_s [9] = '{E_F, E_D, E_R, E_E, E_MS, E_MS, E_MS, E_WI, E_F};
      logic        rdy   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      i_opcode = OP_STORE;
      for (int i = 0; i < 9; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_s[i]) $display("FAIL store_cyc%0d: got %h want %h", i, obs, exp_s[i]);
         else n_pass++;
         i_mem_ready = rdy[i];
      end
      n_total++;
      if (o_retired !== 16'd1) $display("FAIL store_retired: got %0d want 1", o_retired);
      else n_pass++;
   endtask

   // Taken branch, not-taken branch, then jump with taken=0, issued back to back.
   task automatic test_back_to_back_branch();
      logic [13:0] exp_s [16] = '{E_F, E_D, E_R, E_E, E_WL,
                                  E_F, E_D, E_R, E_E, E_WI,
                                  E_F, E_D, E_R, E_E, E_WL, E_F};
      logic [4:0]  ops [4] = '{OP_BRANCH, OP_BRANCH, OP_JUMP, OP_ALU};
      logic        tks [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      i_mem_ready = 1'b1;
      i_opcode = ops[0];
      i_branch_taken = tks[0];
      for (int i = 0; i < 16; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_s[i]) $display("FAIL branch_cyc%0d: got %h want %h", i, obs, exp_s[i]);
         else n_pass++;
         if (i % 5 == 4) begin
            i_opcode = ops[(i + 1) / 5];
            i_branch_taken = tks[(i + 1) / 5];
         end
      end
      n_total++;
      if (o_retired !== 16'd3) $display("FAIL branch_retired: got %0d want 3", o_retired);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [13:0] exp_v;
      do_reset();
      i_opcode = OP_ALU;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         exp_v = (i < 16) ? E_F : E_HE;
         n_total++;
         if (obs !== exp_v) $display("FAIL timeout_cyc%0d: got %h want %h", i, obs, exp_v);
         else n_pass++;
         i_mem_ready = (i >= 17);
      end
      n_total++;
      if (o_retired !== 16'd0) $display("FAIL timeout_retired: got %0d want 0", o_retired);
      else n_pass++;
   endtask

   task automatic test_timeout_edge();
      logic [13:0] exp_v;
      do_reset();
      i_opcode = OP_ALU;
      for (int i = 0; i < 18; i++) begin
         @(negedge i_clk);
         exp_v = (i < 16) ? E_F : ((i == 16) ? E_D : E_R);
         n_total++;
         if (obs !== exp_v) $display("FAIL timeout_edge_cyc%0d: got %h want %h", i, obs, exp_v);
         else n_pass++;
         i_mem_ready = (i == 15);
      end
   endtask

   task automatic test_halt();
      logic [13:0] exp_s [13] = '{E_F, E_D, E_R, E_E, E_WA,
                                  E_F, E_D, E_R, E_E, E_H, E_H, E_H, E_H};
      do_reset();
      i_mem_ready = 1'b1;
      i_opcode = OP_ALU;
      for (int i = 0; i < 13; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_s[i]) $display("FAIL halt_cyc%0d: got %h want %h", i, obs, exp_s[i]);
         else n_pass++;
         if (i == 4) i_opcode = OP_HALT;
      end
      n_total++;
      if (o_retired !== 16'd1) $display("FAIL halt_retired: got %0d want 1", o_retired);
      else n_pass++;
   endtask

   task automatic test_rst_mid_mem();
      logic [13:0] exp_a [12] = '{E_F, E_D, E_R, E_E, E_WA,
                                  E_F, E_D, E_R, E_E, E_ML, E_ML, E_ML};
      logic [13:0] exp_b [7]  = '{E_F, E_D, E_R, E_E, E_ML, E_WA, E_F};
      do_reset();
      i_mem_ready = 1'b1;
      i_opcode = OP_ALU;
      for (int i = 0; i < 12; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_a[i]) $display("FAIL rstmem_pre_cyc%0d: got %h want %h", i, obs, exp_a[i]);
         else n_pass++;
         if (i == 4) i_opcode = OP_LOAD;
         if (i == 8) i_mem_ready = 1'b0;
      end
      n_total++;
      if (o_retired !== 16'd1) $display("FAIL rstmem_retired_before: got %0d want 1", o_retired);
      else n_pass++;
      i_rst = 1'b1;
      @(negedge i_clk);
      n_total++;
      if (obs !== E_RST) $display("FAIL rstmem_reset_outputs: got %h want %h", obs, E_RST);
      else n_pass++;
      n_total++;
      if (o_retired !== 16'd0) $display("FAIL rstmem_reset_retired: got %0d want 0", o_retired);
      else n_pass++;
      i_rst = 1'b0;
      i_mem_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge i_clk);
         n_total++;
         if (obs !== exp_b[i]) $display("FAIL rstmem_load_cyc%0d: got %h want %h", i, obs, exp_b[i]);
         else n_pass++;
      end
      n_total++;
      if (o_retired !== 16'd1) $display("FAIL rstmem_retired_after: got %0d want 1", o_retired);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_wait();
      test_back_to_back_branch();
      test_timeout();
      test_timeout_edge();
      test_halt();
      test_rst_mid_mem();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
